// File: rtl/victim_cache_lru_pkg.sv
// Shared defaults and entry/age types for the LRU victim cache.
package victim_cache_lru_pkg;
  localparam int VC_VICTIM_SIZE = 8;
  localparam int VC_NUM_LOOKUP  = 2;
  localparam int VC_TAG_W       = 29;
  localparam int VC_DATA_W      = 64;
  localparam int VC_CNT_W       = 32;

  typedef logic [$clog2(VC_VICTIM_SIZE)-1:0] victim_age_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_DATA_W-1:0] data;
  } victim_entry_t;
endpackage

// File: rtl/victim_cache_lru_lru_age.sv
// Per-entry LRU ages: applies ordered touches each edge and picks the victim.
module victim_lru_age
  import victim_cache_lru_pkg::*;
#(
  parameter int SIZE  = VC_VICTIM_SIZE,
  parameter int NPORT = VC_NUM_LOOKUP
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [SIZE-1:0]                      valid_i,
  input  logic [NPORT-1:0]                     touch_i,
  input  logic [NPORT-1:0][$clog2(SIZE)-1:0]   touch_idx_i,
  input  logic                                 ins_i,
  input  logic                                 ins_new_i,
  input  logic [$clog2(SIZE)-1:0]              ins_idx_i,
  output logic [$clog2(SIZE)-1:0]              victim_idx_o
);
  localparam int AW = $clog2(SIZE);
  localparam logic [AW-1:0] AMAX = AW'(SIZE - 1);

  logic [SIZE-1:0][AW-1:0] age_q, age_d;

  // Entries no older than the touched one age by one; the touched one becomes MRU.
  function automatic logic [SIZE-1:0][AW-1:0] touch(
    input logic [SIZE-1:0][AW-1:0] a,
    input logic [AW-1:0]           idx,
    input logic [AW-1:0]           prior,
    input logic [SIZE-1:0]         v
  );
    logic [SIZE-1:0][AW-1:0] r;
    r = a;
    for (int j = 0; j < SIZE; j++)
      if (AW'(j) != idx && v[j] && a[j] <= prior && a[j] != AMAX)
        r[j] = a[j] + 1'b1;
    r[idx] = '0;
    return r;
  endfunction

  always_comb begin
    age_d = age_q;
    for (int p = 0; p < NPORT; p++)
      if (touch_i[p])
        age_d = touch(age_d, touch_idx_i[p], age_d[touch_idx_i[p]], valid_i);
    if (ins_i)
      age_d = touch(age_d, ins_idx_i, ins_new_i ? AMAX : age_d[ins_idx_i], valid_i);
  end

  logic          found;
  logic [AW-1:0] best;
  always_comb begin
    found        = 1'b0;
    best         = '0;
    victim_idx_o = '0;
    for (int j = 0; j < SIZE; j++)
      if (valid_i[j] && (!found || age_q[j] > best)) begin
        found        = 1'b1;
        best         = age_q[j];
        victim_idx_o = AW'(j);
      end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
endmodule

// File: rtl/victim_cache_lru.sv
// Fully-associative victim cache: parallel lookups with extract, LRU insert, one-deep dirty writeback.
module victim_cache_lru
  import victim_cache_lru_pkg::*;
#(
  parameter int VICTIM_SIZE = VC_VICTIM_SIZE,
  parameter int NUM_LOOKUP  = VC_NUM_LOOKUP,
  parameter int TAG_W       = VC_TAG_W,
  parameter int DATA_W      = VC_DATA_W,
  parameter int CNT_W       = VC_CNT_W
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LOOKUP-1:0]              lookup_valid,
  input  logic [NUM_LOOKUP-1:0][TAG_W-1:0]   lookup_tag,
  input  logic [NUM_LOOKUP-1:0]              lookup_extract,
  output logic [NUM_LOOKUP-1:0]              lookup_hit,
  output logic [NUM_LOOKUP-1:0][DATA_W-1:0]  lookup_data,
  output logic [NUM_LOOKUP-1:0]              lookup_dirty,
  input  logic                               insert_valid,
  output logic                               insert_ready,
  input  logic [TAG_W-1:0]                   insert_tag,
  input  logic [DATA_W-1:0]                  insert_data,
  input  logic                               insert_dirty,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [TAG_W-1:0]                   wb_tag,
  output logic [DATA_W-1:0]                  wb_data,
  output logic [CNT_W-1:0]                   hit_count,
  output logic [CNT_W-1:0]                   dirty_evict_count
);
  localparam int IW = $clog2(VICTIM_SIZE);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [VICTIM_SIZE-1:0] ent_q, ent_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]         wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0]        wb_data_q, wb_data_d;
  logic [CNT_W-1:0]         hit_cnt_q, hit_cnt_d, dec_cnt_q, dec_cnt_d;

  logic [VICTIM_SIZE-1:0]           valid_vec;
  logic [NUM_LOOKUP-1:0][IW-1:0]    hit_idx;
  logic                             match_any, free_any, evict_dirty, ins_fire;
  logic [IW-1:0]                    match_idx, free_idx, victim_idx, ins_idx;
  logic [CNT_W:0]                   hit_sum;

  always_comb
    for (int e = 0; e < VICTIM_SIZE; e++) valid_vec[e] = ent_q[e].valid;

  always_comb begin
    lookup_hit   = '0;
    lookup_data  = '0;
    lookup_dirty = '0;
    hit_idx      = '0;
    for (int p = 0; p < NUM_LOOKUP; p++)
      for (int e = 0; e < VICTIM_SIZE; e++)
        if (lookup_valid[p] && ent_q[e].valid && ent_q[e].tag == lookup_tag[p]) begin
          lookup_hit[p]   = 1'b1;
          hit_idx[p]      = IW'(e);
          lookup_data[p]  = ent_q[e].data;
          lookup_dirty[p] = ent_q[e].dirty;
        end
  end

  // Target selection sees only start-of-cycle state, so same-cycle extracts never free a slot.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int e = 0; e < VICTIM_SIZE; e++) begin
      if (ent_q[e].valid && ent_q[e].tag == insert_tag) begin
        match_any = 1'b1;
        match_idx = IW'(e);
      end
      if (!ent_q[e].valid && !free_any) begin
        free_any = 1'b1;
        free_idx = IW'(e);
      end
    end
  end

  assign ins_idx      = match_any ? match_idx : (free_any ? free_idx : victim_idx);
  assign evict_dirty  = !match_any && !free_any && ent_q[victim_idx].dirty;
  assign insert_ready = !(wb_valid_q && !wb_ready && evict_dirty);
  assign ins_fire     = insert_valid && insert_ready;

  victim_lru_age #(.SIZE(VICTIM_SIZE), .NPORT(NUM_LOOKUP)) u_age (
    .clock        (clock),
    .reset        (reset),
    .valid_i      (valid_vec),
    .touch_i      (lookup_hit & ~lookup_extract),
    .touch_idx_i  (hit_idx),
    .ins_i        (ins_fire),
    .ins_new_i    (!match_any),
    .ins_idx_i    (ins_idx),
    .victim_idx_o (victim_idx)
  );

  always_comb begin
    ent_d = ent_q;
    for (int p = 0; p < NUM_LOOKUP; p++)
      if (lookup_hit[p] && lookup_extract[p]) ent_d[hit_idx[p]].valid = 1'b0;
    if (ins_fire) begin
      if (match_any) begin
        ent_d[ins_idx].valid = 1'b1;
        ent_d[ins_idx].dirty = ent_q[ins_idx].dirty | insert_dirty;
        ent_d[ins_idx].data  = insert_data;
      end else begin
        ent_d[ins_idx] = {1'b1, insert_dirty, insert_tag, insert_data};
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q && !wb_ready;
    wb_tag_d   = wb_tag_q;
    wb_data_d  = wb_data_q;
    if (ins_fire && evict_dirty) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = ent_q[victim_idx].tag;
      wb_data_d  = ent_q[victim_idx].data;
    end
  end

  always_comb begin
    hit_sum = {1'b0, hit_cnt_q};
    for (int p = 0; p < NUM_LOOKUP; p++) hit_sum = hit_sum + (CNT_W+1)'(lookup_hit[p]);
    hit_cnt_d = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
    dec_cnt_d = (ins_fire && evict_dirty && dec_cnt_q != '1) ? dec_cnt_q + 1'b1 : dec_cnt_q;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ent_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
      hit_cnt_q  <= '0;
      dec_cnt_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
      hit_cnt_q  <= hit_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end

  assign wb_valid          = wb_valid_q;
  assign wb_tag            = wb_tag_q;
  assign wb_data           = wb_data_q;
  assign hit_count         = hit_cnt_q;
  assign dirty_evict_count = dec_cnt_q;
endmodule

// File: tb/tb_victim_cache_lru.sv
// Directed vector table plus randomized traffic against a behavioural victim-cache model.
module tb_victim_cache_lru;
  localparam int VS   = 4;
  localparam int NL   = 2;
  localparam int TW   = 29;
  localparam int DW   = 64;
  localparam int CW   = 8;
  localparam int AMAX = VS - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NL-1:0]          lookup_valid = '0, lookup_extract = '0;
  logic [NL-1:0]          lookup_hit, lookup_dirty;
  logic [NL-1:0][TW-1:0]  lookup_tag = '0;
  logic [NL-1:0][DW-1:0]  lookup_data;
  logic                   insert_valid = 1'b0, insert_dirty = 1'b0, wb_ready = 1'b0;
  logic                   insert_ready, wb_valid;
  logic [TW-1:0]          insert_tag = '0, wb_tag;
  logic [DW-1:0]          insert_data = '0, wb_data;
  logic [CW-1:0]          hit_count, dirty_evict_count;

  always #5 clock = ~clock;

  victim_cache_lru #(.VICTIM_SIZE(VS), .NUM_LOOKUP(NL), .TAG_W(TW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_extract(lookup_extract),
    .lookup_hit(lookup_hit), .lookup_data(lookup_data), .lookup_dirty(lookup_dirty),
    .insert_valid(insert_valid), .insert_ready(insert_ready), .insert_tag(insert_tag),
    .insert_data(insert_data), .insert_dirty(insert_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
    .hit_count(hit_count), .dirty_evict_count(dirty_evict_count)
  );

  int n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_v[VS], m_d[VS], st_v[VS];
  logic [TW-1:0]   m_tag[VS];
  logic [DW-1:0]   m_data[VS];
  int              m_age[VS];
  bit              m_wbv;
  logic [TW-1:0]   m_wbtag;
  logic [DW-1:0]   m_wbdata;
  int              m_hc, m_dec;
  bit [NL-1:0]     x_hit, x_dirty;
  int              x_idx[NL];
  logic [DW-1:0]   x_data[NL];
  bit              x_rdy;
  int              x_kind, x_tgt;

  task automatic model_reset();
    for (int e = 0; e < VS; e++) begin
      m_v[e] = 0; m_d[e] = 0; m_age[e] = 0; m_tag[e] = '0; m_data[e] = '0;
    end
    m_wbv = 0; m_hc = 0; m_dec = 0;
  endtask

  task automatic model_eval();
    int match, free, vic;
    for (int p = 0; p < NL; p++) begin
      x_hit[p] = 0; x_idx[p] = 0; x_data[p] = '0; x_dirty[p] = 0;
      for (int e = 0; e < VS; e++)
        if (lookup_valid[p] && m_v[e] && m_tag[e] == lookup_tag[p]) begin
          x_hit[p] = 1; x_idx[p] = e; x_data[p] = m_data[e]; x_dirty[p] = m_d[e];
        end
    end
    match = -1; free = -1; vic = 0;
    for (int e = 0; e < VS; e++) begin
      if (m_v[e] && m_tag[e] == insert_tag) match = e;
      if (!m_v[e] && free < 0) free = e;
      if (m_age[e] > m_age[vic]) vic = e;
    end
    if (match >= 0)     begin x_kind = 0; x_tgt = match; end
    else if (free >= 0) begin x_kind = 1; x_tgt = free;  end
    else                begin x_kind = 2; x_tgt = vic;   end
    x_rdy = !(m_wbv && !wb_ready && x_kind == 2 && m_d[x_tgt]);
  endtask

  task automatic touch(input int t, input int prior);
    for (int j = 0; j < VS; j++)
      if (j != t && st_v[j] && m_age[j] <= prior)
        m_age[j] = (m_age[j] + 1 > AMAX) ? AMAX : m_age[j] + 1;
    m_age[t] = 0;
  endtask

  task automatic model_edge();
    bit fire;
    int nh;
    fire = insert_valid && x_rdy;
    st_v = m_v;
    nh = 0;
    for (int p = 0; p < NL; p++) nh += x_hit[p];
    m_hc = (m_hc + nh > CMAX) ? CMAX : m_hc + nh;
    if (fire && x_kind == 2 && m_d[x_tgt]) begin
      m_wbv = 1; m_wbtag = m_tag[x_tgt]; m_wbdata = m_data[x_tgt];
      if (m_dec < CMAX) m_dec++;
    end else if (wb_ready) m_wbv = 0;
    for (int p = 0; p < NL; p++)
      if (x_hit[p] && !lookup_extract[p]) touch(x_idx[p], m_age[x_idx[p]]);
    if (fire) touch(x_tgt, x_kind == 0 ? m_age[x_tgt] : AMAX);
    for (int p = 0; p < NL; p++)
      if (x_hit[p] && lookup_extract[p]) m_v[x_idx[p]] = 0;
    if (fire) begin
      m_v[x_tgt] = 1; m_data[x_tgt] = insert_data;
      if (x_kind == 0) m_d[x_tgt] = m_d[x_tgt] | insert_dirty;
      else begin m_d[x_tgt] = insert_dirty; m_tag[x_tgt] = insert_tag; end
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input bit rst, input bit [1:0] lv, input int t0, input int t1,
                       input bit [1:0] ext, input bit iv, input int itag,
                       input logic [DW-1:0] idata, input bit idirty, input bit wbr);
    reset = !rst;
    lookup_valid = lv; lookup_tag[0] = TW'(t0); lookup_tag[1] = TW'(t1);
    lookup_extract = ext;
    insert_valid = iv; insert_tag = TW'(itag); insert_data = idata; insert_dirty = idirty;
    wb_ready = wbr;
  endtask

  task automatic settle();
    #1;
    if (!reset) model_reset();
    model_eval();
    chk("hit", lookup_hit, x_hit);
    for (int p = 0; p < NL; p++) begin
      chk("data", lookup_data[p], x_data[p]);
      chk("dirty", lookup_dirty[p], x_dirty[p]);
    end
    chk("ready", insert_ready, x_rdy);
    chk("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      chk("wb_tag", wb_tag, m_wbtag);
      chk("wb_data", wb_data, m_wbdata);
    end
    chk("hit_count", hit_count, m_hc);
    chk("dirty_evict_count", dirty_evict_count, m_dec);
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
    cyc++;
  endtask

  function automatic logic [DW-1:0] dat(input int tag, input bit d);
    return {d ? 32'hDDDD_0000 : 32'hCCCC_0000, 32'(tag)};
  endfunction

  typedef struct {
    bit rst; bit [1:0] lv; int t0; int t1; bit [1:0] ext;
    bit iv; int itag; bit idirty; bit wbr;
    bit [1:0] e_hit; bit [1:0] e_dirty; bit e_rdy; bit e_wbv; int e_wbtag; int e_dec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit [1:0] lv, input int t0, input int t1, input bit [1:0] ext,
                     input bit iv, input int itag, input bit idirty, input bit wbr,
                     input bit [1:0] e_hit, input bit [1:0] e_dirty, input bit e_rdy,
                     input bit e_wbv, input int e_wbtag, input int e_dec);
    vec_t v;
    v = '{rst, lv, t0, t1, ext, iv, itag, idirty, wbr, e_hit, e_dirty, e_rdy, e_wbv, e_wbtag, e_dec};
    tbl.push_back(v);
  endtask

  task automatic ins(input int tag, input bit d, input bit wbr, input bit rdy,
                     input bit wbv, input int wbtag, input int dec);
    add(0, 2'b00, 0, 0, 2'b00, 1, tag, d, wbr, 2'b00, 2'b00, rdy, wbv, wbtag, dec);
  endtask

  initial begin
    vec_t v;
    @(negedge clock);
    // fill then LRU eviction
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int t = 'h10; t <= 'h13; t++) ins(t, 0, 1, 1, 0, 0, 0);
    add(0, 2'b01, 'h10, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1, 0, 0, 0);
    ins('h14, 0, 1, 1, 0, 0, 0);
    add(0, 2'b11, 'h11, 'h10, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1, 0, 0, 0);
    add(0, 2'b01, 'h14, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1, 0, 0, 0);
    // dirty writeback stall
    add(1, 2'b01, 'h10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int t = 'h20; t <= 'h23; t++) ins(t, 1, 0, 1, 0, 0, 0);
    ins('h24, 1, 0, 1, 0, 0, 0);
    ins('h25, 1, 0, 0, 1, 'h20, 1);
    ins('h25, 1, 1, 1, 1, 'h20, 1);
    add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 'h21, 2);
    add(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 'h21, 2);
    add(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 2);
    // extract frees a slot without eviction
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int t = 'h30; t <= 'h33; t++) ins(t, 1, 1, 1, 0, 0, 0);
    add(0, 2'b10, 0, 'h30, 2'b10, 0, 0, 0, 1, 2'b10, 2'b10, 1, 0, 0, 0);
    add(0, 2'b10, 0, 'h30, 2'b00, 1, 'h34, 1, 1, 2'b00, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11, 'h34, 'h31, 0, 0, 0, 0, 1, 2'b11, 2'b11, 1, 0, 0, 0);
    // same-tag insert merges in place
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int t = 'h40; t <= 'h43; t++) ins(t, 0, 1, 1, 0, 0, 0);
    ins('h40, 1, 0, 1, 0, 0, 0);
    add(0, 2'b11, 'h40, 'h41, 0, 0, 0, 0, 1, 2'b11, 2'b01, 1, 0, 0, 0);
    add(0, 2'b11, 'h42, 'h43, 0, 0, 0, 0, 1, 2'b11, 2'b00, 1, 0, 0, 0);
    // simultaneous hits + insert, then dual extract
    add(0, 2'b11, 'h41, 'h42, 0, 1, 'h50, 0, 1, 2'b11, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11, 'h41, 'h51, 0, 1, 'h51, 0, 1, 2'b01, 2'b00, 1, 1, 'h40, 1);
    add(0, 2'b11, 'h51, 'h50, 0, 0, 0, 0, 1, 2'b11, 2'b00, 1, 0, 0, 1);
    add(0, 2'b11, 'h50, 'h50, 2'b11, 0, 0, 0, 1, 2'b11, 2'b00, 1, 0, 0, 1);
    add(0, 2'b01, 'h50, 0, 0, 1, 'h52, 0, 1, 2'b00, 2'b00, 1, 0, 0, 1);
    add(0, 2'b11, 'h51, 'h42, 0, 0, 0, 0, 1, 2'b11, 2'b00, 1, 0, 0, 1);
    add(0, 2'b11, 'h52, 'h41, 0, 0, 0, 0, 1, 2'b11, 2'b00, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.rst, v.lv, v.t0, v.t1, v.ext, v.iv, v.itag, dat(v.itag, v.idirty), v.idirty, v.wbr);
      settle();
      chk("tbl_hit", lookup_hit, v.e_hit);
      chk("tbl_dirty", lookup_dirty, v.e_dirty);
      chk("tbl_ready", insert_ready, v.e_rdy);
      chk("tbl_wb_valid", wb_valid, v.e_wbv);
      if (v.e_wbv) chk("tbl_wb_tag", wb_tag, v.e_wbtag);
      chk("tbl_dirty_evict", dirty_evict_count, v.e_dec);
      advance();
    end

    // hit counter saturation
    for (int i = 0; i < 140; i++) begin
      drive(0, 2'b11, 'h52, 'h41, 0, 0, 0, '0, 0, 1);
      settle();
      advance();
    end
    chk("hit_count_sat", hit_count, CMAX);

    // randomized traffic over a small tag pool
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] ext;
      ext[0] = ($urandom % 5 == 0);
      ext[1] = ($urandom % 5 == 0);
      drive($urandom % 300 == 0, 2'($urandom), 'h60 + int'($urandom % 10), 'h60 + int'($urandom % 10),
            ext, $urandom % 10 < 6, 'h60 + int'($urandom % 10), {$urandom, $urandom},
            1'($urandom), 1'($urandom));
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
